// File: rtl/mrv1_tw_barrier_unit.sv
// Multi-barrier warp synchronisation: tracks per-barrier arrival masks, parks warps, releases on fill.
// Optional watchdog forced release enabled by defining MRV1_TW_BAR_TIMEOUT_EN.
module mrv1_tw_barrier_unit #(
   parameter  int unsigned NUM_TW_P       = 8,
   parameter  int unsigned NUM_BARRIERS_P = 8,
   parameter  int unsigned ITAG_WIDTH_P   = 6,
   parameter  int unsigned TIMEOUT_P      = 1024,
   localparam int unsigned WID_W          = (NUM_TW_P > 1) ? $clog2(NUM_TW_P) : 1,
   localparam int unsigned ID_W           = (NUM_BARRIERS_P > 1) ? $clog2(NUM_BARRIERS_P) : 1
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    bar_req_i,
   output logic                    bar_rdy_o,
   input  logic [ID_W-1:0]         bar_id_i,
   input  logic [WID_W-1:0]        bar_wid_i,
   input  logic [WID_W-1:0]        bar_size_m1_i,
   input  logic [ITAG_WIDTH_P-1:0] bar_itag_i,
   output logic                    done_o,
   output logic [ITAG_WIDTH_P-1:0] done_itag_o,
   output logic                    release_vld_o,
   input  logic                    release_rdy_i,
   output logic [ID_W-1:0]         release_id_o,
   output logic [NUM_TW_P-1:0]     release_wmask_o,
   output logic                    release_timeout_o,
   output logic [NUM_TW_P-1:0]     stall_wmask_o,
   output logic                    err_o
);
   localparam int unsigned CNT_W   = $clog2(NUM_TW_P + 1);
   localparam logic [0:0]  ST_IDLE = 1'b0;
   localparam logic [0:0]  ST_FILL = 1'b1;

   logic [0:0]              state_q [NUM_BARRIERS_P];
   logic [0:0]              state_d [NUM_BARRIERS_P];
   logic [NUM_TW_P-1:0]     mask_q  [NUM_BARRIERS_P];
   logic [NUM_TW_P-1:0]     mask_d  [NUM_BARRIERS_P];
   logic [CNT_W-1:0]        cnt_q   [NUM_BARRIERS_P];
   logic [CNT_W-1:0]        cnt_d   [NUM_BARRIERS_P];
   logic [WID_W-1:0]        size_q  [NUM_BARRIERS_P];
   logic [WID_W-1:0]        size_d  [NUM_BARRIERS_P];
   logic                    rel_vld_q, rel_vld_d;
   logic [ID_W-1:0]         rel_id_q, rel_id_d;
   logic [NUM_TW_P-1:0]     rel_wmask_q, rel_wmask_d;
   logic                    done_q, done_d;
   logic [ITAG_WIDTH_P-1:0] done_itag_q, done_itag_d;
   logic                    err_q, err_d;

   logic                    acc_c, id_ok_c, dup_c, mism_c, arrive_c, complete_c;
   logic [NUM_TW_P-1:0]     wbit_c;
   logic [0:0]              sel_state_c;
   logic [NUM_TW_P-1:0]     sel_mask_c;
   logic [CNT_W-1:0]        sel_cnt_c;
   logic [WID_W-1:0]        sel_size_c, size_eff_c;

`ifdef MRV1_TW_BAR_TIMEOUT_EN
   localparam int unsigned  TMR_W   = (TIMEOUT_P > 1) ? $clog2(TIMEOUT_P) : 1;
   localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_P - 1);
   logic [TMR_W-1:0]        tmr_q [NUM_BARRIERS_P];
   logic [TMR_W-1:0]        tmr_d [NUM_BARRIERS_P];
   logic                    rel_to_q, rel_to_d;
   logic                    to_found;
   assign release_timeout_o = rel_to_q;
`else
   assign release_timeout_o = 1'b0;
`endif

   assign bar_rdy_o = !(rel_vld_q && !release_rdy_i);
   assign acc_c     = bar_req_i && bar_rdy_o;
   assign id_ok_c   = 32'(bar_id_i) < NUM_BARRIERS_P;
   assign wbit_c    = NUM_TW_P'(1) << bar_wid_i;

   // Selected barrier view; out-of-range ids select nothing
   always_comb begin
      sel_state_c = ST_IDLE;
      sel_mask_c  = '0;
      sel_cnt_c   = '0;
      sel_size_c  = '0;
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
         if (ID_W'(b) == bar_id_i) begin
            sel_state_c = state_q[b];
            sel_mask_c  = mask_q[b];
            sel_cnt_c   = cnt_q[b];
            sel_size_c  = size_q[b];
         end
      end
   end

   assign dup_c      = id_ok_c && ((sel_mask_c & wbit_c) != '0);
   assign mism_c     = id_ok_c && (sel_state_c == ST_FILL) && (bar_size_m1_i != sel_size_c);
   assign size_eff_c = (sel_state_c == ST_FILL) ? sel_size_c : bar_size_m1_i;
   assign arrive_c   = acc_c && id_ok_c && !dup_c;
   assign complete_c = arrive_c && (sel_cnt_c == CNT_W'(size_eff_c));

   always_comb begin
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
         state_d[b] = state_q[b];
         mask_d[b]  = mask_q[b];
         cnt_d[b]   = cnt_q[b];
         size_d[b]  = size_q[b];
      end
      rel_vld_d   = rel_vld_q;
      rel_id_d    = rel_id_q;
      rel_wmask_d = rel_wmask_q;
      done_d      = acc_c;
      done_itag_d = acc_c ? bar_itag_i : done_itag_q;
      err_d       = acc_c && (!id_ok_c || dup_c || mism_c);

      if (rel_vld_q && release_rdy_i) begin
         rel_vld_d   = 1'b0;
         rel_id_d    = '0;
         rel_wmask_d = '0;
      end

      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
         if (arrive_c && (ID_W'(b) == bar_id_i)) begin
            if (complete_c) begin
               state_d[b] = ST_IDLE;
               mask_d[b]  = '0;
               cnt_d[b]   = '0;
               size_d[b]  = '0;
            end else begin
               state_d[b] = ST_FILL;
               mask_d[b]  = mask_q[b] | wbit_c;
               cnt_d[b]   = cnt_q[b] + CNT_W'(1);
               size_d[b]  = size_eff_c;
            end
         end
      end

      if (complete_c) begin
         rel_vld_d   = 1'b1;
         rel_id_d    = bar_id_i;
         rel_wmask_d = sel_mask_c | wbit_c;
      end

`ifdef MRV1_TW_BAR_TIMEOUT_EN
      rel_to_d = ((rel_vld_q && release_rdy_i) || complete_c) ? 1'b0 : rel_to_q;
      to_found = 1'b0;
      for (int b = 0; b < NUM_BARRIERS_P; b++) begin
         tmr_d[b] = tmr_q[b];
         if ((state_q[b] == ST_FILL) && (tmr_q[b] != TMR_MAX)) tmr_d[b] = tmr_q[b] + TMR_W'(1);
         if (arrive_c && (ID_W'(b) == bar_id_i)) tmr_d[b] = '0;
      end
      // Lowest expired barrier takes a free release slot unless a normal completion claims it
      if (!complete_c && (!rel_vld_q || release_rdy_i)) begin
         for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            if (!to_found && (state_q[b] == ST_FILL) && (tmr_q[b] == TMR_MAX) &&
                !(arrive_c && (ID_W'(b) == bar_id_i))) begin
               to_found    = 1'b1;
               state_d[b]  = ST_IDLE;
               mask_d[b]   = '0;
               cnt_d[b]    = '0;
               size_d[b]   = '0;
               tmr_d[b]    = '0;
               rel_vld_d   = 1'b1;
               rel_id_d    = ID_W'(b);
               rel_wmask_d = mask_q[b];
               rel_to_d    = 1'b1;
               err_d       = 1'b1;
            end
         end
      end
`endif
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            state_q[b] <= ST_IDLE;
            mask_q[b]  <= '0;
            cnt_q[b]   <= '0;
            size_q[b]  <= '0;
         end
         rel_vld_q   <= 1'b0;
         rel_id_q    <= '0;
         rel_wmask_q <= '0;
         done_q      <= 1'b0;
         done_itag_q <= '0;
         err_q       <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BARRIERS_P; b++) begin
            state_q[b] <= state_d[b];
            mask_q[b]  <= mask_d[b];
            cnt_q[b]   <= cnt_d[b];
            size_q[b]  <= size_d[b];
         end
         rel_vld_q   <= rel_vld_d;
         rel_id_q    <= rel_id_d;
         rel_wmask_q <= rel_wmask_d;
         done_q      <= done_d;
         done_itag_q <= done_itag_d;
         err_q       <= err_d;
      end
   end

`ifdef MRV1_TW_BAR_TIMEOUT_EN
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int b = 0; b < NUM_BARRIERS_P; b++) tmr_q[b] <= '0;
         rel_to_q <= 1'b0;
      end else begin
         for (int b = 0; b < NUM_BARRIERS_P; b++) tmr_q[b] <= tmr_d[b];
         rel_to_q <= rel_to_d;
      end
   end
`endif

   // Parked warps: every live barrier mask plus the pending release
   always_comb begin
      stall_wmask_o = rel_vld_q ? rel_wmask_q : '0;
      for (int b = 0; b < NUM_BARRIERS_P; b++) stall_wmask_o = stall_wmask_o | mask_q[b];
   end

   assign done_o          = done_q;
   assign done_itag_o     = done_itag_q;
   assign release_vld_o   = rel_vld_q;
   assign release_id_o    = rel_id_q;
   assign release_wmask_o = rel_wmask_q;
   assign err_o           = err_q;
endmodule

// File: tb/tb_mrv1_tw_barrier_unit.sv
// Scoreboard bench for mrv1_tw_barrier_unit: directed scenarios plus randomized arrivals vs a mask/popcount model.
module tb_mrv1_tw_barrier_unit;
   localparam int unsigned NTW = 8;
   localparam int unsigned NB  = 8;
   localparam int unsigned IW  = 6;

   typedef struct { logic [2:0] id; logic [7:0] wmask; } rel_t;
   typedef struct { logic [IW-1:0] itag; logic err; } done_t;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          bar_req_i;
   logic          bar_rdy_o;
   logic [2:0]    bar_id_i;
   logic [2:0]    bar_wid_i;
   logic [2:0]    bar_size_m1_i;
   logic [IW-1:0] bar_itag_i;
   logic          done_o;
   logic [IW-1:0] done_itag_o;
   logic          release_vld_o;
   logic          release_rdy_i;
   logic [2:0]    release_id_o;
   logic [7:0]    release_wmask_o;
   logic          release_timeout_o;
   logic [7:0]    stall_wmask_o;
   logic          err_o;

   mrv1_tw_barrier_unit #(
      .NUM_TW_P(NTW), .NUM_BARRIERS_P(NB), .ITAG_WIDTH_P(IW), .TIMEOUT_P(1024)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .bar_req_i(bar_req_i), .bar_rdy_o(bar_rdy_o), .bar_id_i(bar_id_i),
      .bar_wid_i(bar_wid_i), .bar_size_m1_i(bar_size_m1_i), .bar_itag_i(bar_itag_i),
      .done_o(done_o), .done_itag_o(done_itag_o),
      .release_vld_o(release_vld_o), .release_rdy_i(release_rdy_i),
      .release_id_o(release_id_o), .release_wmask_o(release_wmask_o),
      .release_timeout_o(release_timeout_o), .stall_wmask_o(stall_wmask_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int unsigned nchecks = 0;
   int unsigned nerrors = 0;
   logic        mon_en  = 1'b0;

   // Reference model: arrival sets per barrier, latched size, expected output queues
   logic [7:0]  m_mask [NB];
   int          m_size [NB];
   rel_t        m_rel_q [$];
   done_t       d_q [$];
   logic        m_done_exp = 1'b0;
   int          rsz [NB];

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchecks++;
      if (act !== exp) begin
         nerrors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endfunction

   task automatic model_edge(input logic rst, input logic acc, input logic rrdy,
                             input logic [2:0] id, input logic [2:0] wid,
                             input logic [2:0] sz, input logic [IW-1:0] itag);
      done_t      d;
      rel_t       r;
      logic [7:0] nm;
      if (!rst) begin
         for (int i = 0; i < NB; i++) begin m_mask[i] = '0; m_size[i] = 0; end
         m_rel_q.delete();
         m_done_exp = 1'b0;
         return;
      end
      if (m_rel_q.size() != 0 && rrdy) void'(m_rel_q.pop_front());
      m_done_exp = acc;
      if (!acc) return;
      d.itag = itag;
      d.err  = 1'b0;
      if (int'(id) >= NB) d.err = 1'b1;
      else if (m_mask[id][wid]) d.err = 1'b1;
      else begin
         if (m_mask[id] == 8'd0) m_size[id] = int'(sz);
         else if (int'(sz) != m_size[id]) d.err = 1'b1;
         nm = m_mask[id] | (8'd1 << wid);
         if ($countones(nm) == m_size[id] + 1) begin
            r.id = id; r.wmask = nm;
            m_rel_q.push_back(r);
            m_mask[id] = '0;
         end else m_mask[id] = nm;
      end
      d_q.push_back(d);
   endtask

   task automatic step(input logic rst, input logic req, input logic [2:0] id, input logic [2:0] wid,
                       input logic [2:0] sz, input logic [IW-1:0] itag, input logic rrdy);
      logic acc;
      rst_ni = rst; bar_req_i = req; bar_id_i = id; bar_wid_i = wid;
      bar_size_m1_i = sz; bar_itag_i = itag; release_rdy_i = rrdy;
      acc = rst && req && !(m_rel_q.size() != 0 && !rrdy);
      @(posedge clk_i);
      model_edge(rst, acc, rrdy, id, wid, sz, itag);
      #1;
   endtask

   task automatic idle(input int n, input logic rrdy);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 3'd0, 3'd0, 3'd0, '0, rrdy);
   endtask

   task automatic reset_checks();
      chk("rst_rel_vld", release_vld_o, 0);
      chk("rst_rel_id", release_id_o, 0);
      chk("rst_rel_wmask", release_wmask_o, 0);
      chk("rst_rel_to", release_timeout_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_done_itag", done_itag_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_stall", stall_wmask_o, 0);
   endtask

   // Monitor: compares DUT outputs against the model every cycle, away from the active edge
   always @(negedge clk_i) begin
      done_t      d;
      logic [7:0] exp_st;
      if (mon_en) begin
         chk("bar_rdy", bar_rdy_o, !(m_rel_q.size() != 0 && !release_rdy_i));
         chk("done", done_o, m_done_exp);
         if (done_o) begin
            if (d_q.size() == 0) begin
               nchecks++; nerrors++;
               $display("FAIL done_q: done_o with no expected arrival at %0t", $time);
            end else begin
               d = d_q.pop_front();
               chk("done_itag", done_itag_o, d.itag);
               chk("err", err_o, d.err);
            end
         end else chk("err_idle", err_o, 0);
         chk("rel_vld", release_vld_o, m_rel_q.size() != 0);
         if (m_rel_q.size() != 0 && release_vld_o) begin
            chk("rel_id", release_id_o, m_rel_q[0].id);
            chk("rel_wmask", release_wmask_o, m_rel_q[0].wmask);
         end
         chk("rel_timeout", release_timeout_o, 0);
         exp_st = (m_rel_q.size() != 0) ? m_rel_q[0].wmask : 8'd0;
         for (int i = 0; i < NB; i++) exp_st |= m_mask[i];
         chk("stall_wmask", stall_wmask_o, exp_st);
      end
   end

   initial begin
      step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, '0, 1'b0);
      step(1'b0, 1'b1, 3'd1, 3'd2, 3'd0, 6'h11, 1'b1);
      reset_checks();
      mon_en = 1'b1;

      // Four warps fill barrier 2
      step(1'b1, 1'b1, 3'd2, 3'd0, 3'd3, 6'h01, 1'b1);
      step(1'b1, 1'b1, 3'd2, 3'd1, 3'd3, 6'h02, 1'b1);
      step(1'b1, 1'b1, 3'd2, 3'd3, 3'd3, 6'h03, 1'b1);
      step(1'b1, 1'b1, 3'd2, 3'd5, 3'd3, 6'h04, 1'b1);
      idle(2, 1'b1);

      // Single-warp barrier completes on first arrival
      step(1'b1, 1'b1, 3'd0, 3'd6, 3'd0, 6'h05, 1'b1);
      idle(2, 1'b1);

      // Stalled release blocks new arrivals, then reloads on the accepting cycle
      step(1'b1, 1'b1, 3'd6, 3'd0, 3'd1, 6'h06, 1'b0);
      step(1'b1, 1'b1, 3'd6, 3'd1, 3'd1, 6'h07, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd2, 3'd7, 3'd0, 6'h08, 1'b0);
      step(1'b1, 1'b1, 3'd2, 3'd7, 3'd0, 6'h09, 1'b1);
      idle(2, 1'b1);

      // Duplicate and size mismatch on barrier 4
      step(1'b1, 1'b1, 3'd4, 3'd1, 3'd2, 6'h0A, 1'b1);
      step(1'b1, 1'b1, 3'd4, 3'd1, 3'd2, 6'h0B, 1'b1);
      step(1'b1, 1'b1, 3'd4, 3'd2, 3'd1, 6'h0C, 1'b1);
      idle(2, 1'b1);
      step(1'b1, 1'b1, 3'd4, 3'd3, 3'd2, 6'h0D, 1'b1);
      idle(2, 1'b1);

      // Back-to-back completions on barriers 1 and 5
      step(1'b1, 1'b1, 3'd1, 3'd0, 3'd1, 6'h10, 1'b1);
      step(1'b1, 1'b1, 3'd5, 3'd2, 3'd1, 6'h11, 1'b1);
      step(1'b1, 1'b1, 3'd1, 3'd1, 3'd1, 6'h12, 1'b1);
      step(1'b1, 1'b1, 3'd5, 3'd3, 3'd1, 6'h13, 1'b1);
      idle(2, 1'b1);

      // Reset mid-fill of barrier 3, then a fresh single-warp fill
      step(1'b1, 1'b1, 3'd3, 3'd0, 3'd3, 6'h14, 1'b1);
      step(1'b1, 1'b1, 3'd3, 3'd1, 3'd3, 6'h15, 1'b1);
      step(1'b0, 1'b0, 3'd0, 3'd0, 3'd0, '0, 1'b1);
      reset_checks();
      step(1'b1, 1'b1, 3'd3, 3'd4, 3'd0, 6'h16, 1'b1);
      idle(2, 1'b1);

      // Randomized arrivals with mostly consistent sizes and a random scheduler
      for (int i = 0; i < NB; i++) rsz[i] = $urandom_range(3);
      for (int n = 0; n < 600; n++) begin
         logic [2:0] id, wid, sz;
         id  = 3'($urandom_range(NB - 1));
         wid = 3'($urandom_range(NTW - 1));
         if (m_mask[id] == 8'd0) rsz[id] = $urandom_range(3);
         sz  = ($urandom_range(9) == 0) ? 3'($urandom_range(7)) : 3'(rsz[id]);
         step(($urandom_range(99) != 0), ($urandom_range(9) < 7), id, wid, sz,
              IW'($urandom), ($urandom_range(3) != 0));
      end

      idle(4, 1'b1);
      chk("drain_done_q", d_q.size(), 0);
      chk("drain_rel_q", m_rel_q.size(), 0);
      mon_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end
endmodule
